// File: rtl/fifo_priority_drain.sv
// rtl/fifo_priority_drain.sv - read-side drain controller for the two-class priority FIFO
// Reads words with their class tag into a 3-entry skid buffer and streams them out as valid/ready.
module fifo_priority_drain #(
  parameter int DATA_WIDTH   = 16,
  parameter int CNT_WIDTH    = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hp_empty,
  input  logic                  lp_empty,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_prio,
  output logic [CNT_WIDTH-1:0]  hp_served,
  output logic [CNT_WIDTH-1:0]  lp_served,
  output logic                  lp_starved
);

  localparam int RUN_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STARVE_LIMIT);

  logic [DATA_WIDTH-1:0] buf_data [3];
  logic [2:0]            buf_prio;
  logic [1:0]            occ;
  logic [1:0]            wr_idx;
  logic                  inflight;
  logic                  tag;
  logic [RUN_W-1:0]      run;
  logic                  push;
  logic                  pop;

  // Reserve a buffer slot for every word already requested so the buffer cannot overflow.
  assign rd_en      = !rst && (!hp_empty || !lp_empty) &&
                      (({1'b0, occ} + {2'b00, inflight}) < 3'd3);
  assign push       = inflight;
  assign m_valid    = (occ != 2'd0);
  assign pop        = m_valid && m_ready;
  assign m_data     = buf_data[0];
  assign m_prio     = buf_prio[0];
  assign lp_starved = (run >= RUN_MAX);

  always_comb begin
    wr_idx = occ;
    if (pop) wr_idx = occ - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ       <= 2'd0;
      inflight  <= 1'b0;
      tag       <= 1'b0;
      run       <= '0;
      hp_served <= '0;
      lp_served <= '0;
      buf_prio  <= 3'b000;
      for (int i = 0; i < 3; i++) buf_data[i] <= '0;
    end else begin
      inflight <= rd_en;
      tag      <= !hp_empty;

      if (pop) begin
        buf_data[0] <= buf_data[1];
        buf_data[1] <= buf_data[2];
        buf_prio    <= {buf_prio[2], buf_prio[2:1]};
      end
      // Placed after the shift so a simultaneous push lands behind the remaining words.
      if (push) begin
        buf_data[wr_idx] <= dout;
        buf_prio[wr_idx] <= tag;
      end
      occ <= occ + 2'(push) - 2'(pop);

      if (push && tag && (hp_served != '1))
        hp_served <= hp_served + CNT_WIDTH'(1);
      if (push && !tag && (lp_served != '1))
        lp_served <= lp_served + CNT_WIDTH'(1);

      if (lp_empty)
        run <= '0;
      else if (rd_en && !hp_empty) begin
        if (run != RUN_MAX) run <= run + RUN_W'(1);
      end else if (rd_en)
        run <= '0;
    end
  end

endmodule

// File: tb/tb_fifo_priority_drain.sv
// tb/tb_fifo_priority_drain.sv - self-checking bench for fifo_priority_drain
// Queue-based FIFO and scoreboard model; table vectors, corner sequences, random traffic.
module tb_fifo_priority_drain;
  localparam int DW   = 16;
  localparam int CW   = 3;
  localparam int SL   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hp_empty = 1'b1;
  logic          lp_empty = 1'b1;
  logic          m_ready = 1'b0;
  logic [DW-1:0] dout = '0;
  logic          rd_en, m_valid, m_prio, lp_starved;
  logic [DW-1:0] m_data;
  logic [CW-1:0] hp_served, lp_served;

  fifo_priority_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst), .hp_empty(hp_empty), .lp_empty(lp_empty), .rd_en(rd_en),
    .dout(dout), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_prio(m_prio),
    .hp_served(hp_served), .lp_served(lp_served), .lp_starved(lp_starved)
  );

  always #5 clk = ~clk;

  typedef struct {logic prio; logic [DW-1:0] data;} word_t;
  typedef struct {int n_hp; int n_lp; int exp_hp; int exp_lp;} vec_t;

  logic [DW-1:0] hp_q[$], lp_q[$];
  word_t exp_q[$], got_q[$];
  int  n_checks = 0, n_fail = 0;
  bit  chk_en = 0;
  bit  cap_pend = 0, cap_prio = 0, prev_stall = 0;
  int  hp_cap = 0, lp_cap = 0, run = 0, outstanding = 0;
  logic [DW-1:0] prev_data;
  logic prev_prio;
  logic s_rst, s_rd, s_valid, s_prio, s_starved, s_hpe, s_lpe;
  logic [DW-1:0] s_data;
  logic [CW-1:0] s_hps, s_lps;

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic upd_flags();
    hp_empty = (hp_q.size() == 0);
    lp_empty = (lp_q.size() == 0);
  endtask

  task automatic push_hp(input logic [DW-1:0] d);
    hp_q.push_back(d);
    upd_flags();
  endtask

  task automatic push_lp(input logic [DW-1:0] d);
    lp_q.push_back(d);
    upd_flags();
  endtask

  task automatic tick();
    word_t w;
    @(negedge clk);
    s_rst = rst; s_rd = rd_en; s_valid = m_valid; s_prio = m_prio; s_data = m_data;
    s_starved = lp_starved; s_hpe = hp_empty; s_lpe = lp_empty;
    s_hps = hp_served; s_lps = lp_served;
    if (chk_en) begin
      chk("hp_served", 32'(hp_served), 32'(sat(hp_cap)));
      chk("lp_served", 32'(lp_served), 32'(sat(lp_cap)));
      chk("lp_starved", 32'(lp_starved), 32'(run >= SL));
      chk("rd_on_empty", 32'(rd_en && hp_empty && lp_empty), 32'(0));
      chk("outstanding_le_3", 32'(outstanding <= 3), 32'(1));
      if (prev_stall) begin
        chk("held_valid", 32'(m_valid), 32'(1));
        chk("held_data", 32'(m_data), 32'(prev_data));
        chk("held_prio", 32'(m_prio), 32'(prev_prio));
      end
      if (!rst && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", m_data, $time);
        end else begin
          w = exp_q.pop_front();
          chk("out_data", 32'(m_data), 32'(w.data));
          chk("out_prio", 32'(m_prio), 32'(w.prio));
          outstanding--;
        end
        got_q.push_back('{m_prio, m_data});
      end
      prev_stall = !rst && m_valid && !m_ready;
      prev_data  = m_data;
      prev_prio  = m_prio;
    end
    @(posedge clk); #1;
    if (s_rst) begin
      hp_q.delete(); lp_q.delete(); exp_q.delete();
      cap_pend = 0; hp_cap = 0; lp_cap = 0; run = 0; outstanding = 0;
      prev_stall = 0; chk_en = 1;
    end else begin
      if (cap_pend) begin
        if (cap_prio) hp_cap++; else lp_cap++;
        cap_pend = 0;
      end
      if (s_lpe) run = 0;
      else if (s_rd && !s_hpe) run++;
      else if (s_rd) run = 0;
      if (s_rd) begin
        w = '{1'b0, '0};
        if (hp_q.size() > 0) w = '{1'b1, hp_q.pop_front()};
        else if (lp_q.size() > 0) w = '{1'b0, lp_q.pop_front()};
        dout = w.data;
        exp_q.push_back(w);
        cap_pend = 1; cap_prio = w.prio;
        outstanding++;
      end
    end
    upd_flags();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got_q.delete();
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while ((hp_q.size() + lp_q.size() + exp_q.size()) != 0 && c < maxc) begin
      tick();
      c++;
    end
    tick();
    if (c >= maxc) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    logic [DW-1:0] t1_lp[3];
    logic [DW-1:0] t1_hp[2];
    word_t t1_exp[5];
    int cnt, gaps, f, t4, tl, hp_iss, c;
    logic vv[20];
    logic st[20];

    vecs[0] = '{2, 3, 2, 3};
    vecs[1] = '{10, 0, 7, 0};
    vecs[2] = '{0, 6, 0, 6};
    vecs[3] = '{6, 1, 6, 1};
    vecs[4] = '{9, 9, 7, 7};
    t1_lp  = '{16'hA124, 16'hA267, 16'hA3B4};
    t1_hp  = '{16'hB1B5, 16'hB278};
    t1_exp = '{'{1'b1, 16'hB1B5}, '{1'b1, 16'hB278}, '{1'b0, 16'hA124},
               '{1'b0, 16'hA267}, '{1'b0, 16'hA3B4}};

    // reset state
    tick();
    rst = 1'b0;
    tick();
    chk("reset_rd_en", 32'(s_rd), 32'(0));
    chk("reset_m_valid", 32'(s_valid), 32'(0));
    chk("reset_m_data", 32'(s_data), 32'(0));
    chk("reset_m_prio", 32'(s_prio), 32'(0));
    chk("reset_starved", 32'(s_starved), 32'(0));
    chk("reset_hp_served", 32'(s_hps), 32'(0));
    chk("reset_lp_served", 32'(s_lps), 32'(0));

    // table vectors: class mix, counter saturation at CW bits
    for (int i = 0; i < 5; i++) begin
      do_reset();
      m_ready = 1'b1;
      for (int k = 0; k < vecs[i].n_lp; k++) push_lp((i == 0) ? t1_lp[k] : DW'(16'hA000 + k));
      for (int k = 0; k < vecs[i].n_hp; k++) push_hp((i == 0) ? t1_hp[k] : DW'(16'hB000 + k));
      drain(80);
      chk("vec_hp_served", 32'(hp_served), 32'(vecs[i].exp_hp));
      chk("vec_lp_served", 32'(lp_served), 32'(vecs[i].exp_lp));
      chk("vec_word_count", 32'(got_q.size()), 32'(vecs[i].n_hp + vecs[i].n_lp));
      if (i == 0 && got_q.size() == 5)
        for (int k = 0; k < 5; k++) begin
          chk("t1_order_data", 32'(got_q[k].data), 32'(t1_exp[k].data));
          chk("t1_order_prio", 32'(got_q[k].prio), 32'(t1_exp[k].prio));
        end
    end

    // backpressure: only 3 reads, head held, then gapless drain
    do_reset();
    m_ready = 1'b0;
    for (int k = 0; k < 8; k++) push_lp(DW'(16'hA000 + k));
    cnt = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      cnt += int'(s_rd);
    end
    chk("bp_rd_pulses", 32'(cnt), 32'(3));
    chk("bp_valid", 32'(s_valid), 32'(1));
    chk("bp_head", 32'(s_data), 32'(16'hA000));
    m_ready = 1'b1;
    gaps = 0; c = 0;
    while (got_q.size() < 8 && c < 30) begin
      tick();
      c++;
      if (got_q.size() > 0 && got_q.size() < 8 && !s_valid) gaps++;
    end
    chk("bp_delivered", 32'(got_q.size()), 32'(8));
    chk("bp_gaps", 32'(gaps), 32'(0));

    // throughput: 8 consecutive valid cycles starting 2 after the first read
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 8; k++) push_hp(DW'(16'hB000 + k));
    f = -1;
    for (int t = 0; t < 16; t++) begin
      tick();
      vv[t] = s_valid;
      if (s_rd && f < 0) f = t;
    end
    chk("tp_first_rd_seen", 32'(f >= 0 && f < 4), 32'(1));
    if (f >= 0 && f < 4) begin
      chk("tp_latency_gap", 32'(vv[f+1]), 32'(0));
      for (int t = f + 2; t < f + 10; t++) chk("tp_valid_run", 32'(vv[t]), 32'(1));
      chk("tp_run_end", 32'(vv[f+10]), 32'(0));
    end

    // starvation flag
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 6; k++) push_hp(DW'(16'hB100 + k));
    push_lp(16'hA100);
    t4 = -1; tl = -1; hp_iss = 0;
    for (int t = 0; t < 16; t++) begin
      tick();
      st[t] = s_starved;
      if (s_rd && !s_hpe) begin
        hp_iss++;
        if (hp_iss == 4) t4 = t;
      end else if (s_rd && tl < 0) tl = t;
    end
    chk("starve_seen", 32'(t4 >= 0 && tl > t4 && tl < 15), 32'(1));
    if (t4 >= 0 && tl > t4 && tl < 15) begin
      chk("starve_before", 32'(st[t4]), 32'(0));
      chk("starve_rise", 32'(st[t4+1]), 32'(1));
      chk("starve_at_lp", 32'(st[tl]), 32'(1));
      chk("starve_clear", 32'(st[tl+1]), 32'(0));
    end
    drain(40);

    // reset with 2 buffered and 1 in flight
    do_reset();
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) push_lp(DW'(16'hD000 + k));
    tick(); tick(); tick();
    chk("pre_reset_rd", 32'(s_rd), 32'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got_q.delete();
    tick();
    chk("post_reset_valid", 32'(s_valid), 32'(0));
    chk("post_reset_rd", 32'(s_rd), 32'(0));
    chk("post_reset_hp", 32'(s_hps), 32'(0));
    chk("post_reset_lp", 32'(s_lps), 32'(0));
    m_ready = 1'b1;
    push_lp(16'hC001);
    push_lp(16'hC002);
    c = 0;
    while (got_q.size() == 0 && c < 10) begin
      tick();
      c++;
    end
    chk("refill_got", 32'(got_q.size() > 0), 32'(1));
    if (got_q.size() > 0) chk("refill_first", 32'(got_q[0].data), 32'(16'hC001));
    drain(20);

    // random traffic against the model
    do_reset();
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 3) == 0) push_hp(DW'($urandom));
      if ($urandom_range(0, 2) == 0) push_lp(DW'($urandom));
      m_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    m_ready = 1'b1;
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
